cmd_frame_ctrl: RTL and testbench

Command-frame controller between the UART receiver and the register file, ALU and UART transmitter of the CREM top level. Consumes validated RX bytes, parses the four command frames (0xAA write, 0xBB read, 0xCC ALU on addressed operands, 0xDD ALU on reg0/reg1), sequences register-file and ALU accesses, and hands response bytes to the TX path. It is the stage directly downstream of the UART RX and upstream of the UART TX.

---
 rtl/cmd_pkg.sv | 40 ++++
 rtl/cmd_frame_ctrl_if.sv | 41 ++++
 rtl/cmd_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cmd_frame_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared definitions for the command-frame controller: command bytes,
// FSM state encoding and ALU function codes.
package cmd_pkg;

   // Frame header bytes
   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU     = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   // Byte-collect states first, then execute states
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_W_ADDR,
      ST_W_DATA,
      ST_R_ADDR,
      ST_A_OPA,
      ST_A_OPB,
      ST_A_FUNC,
      ST_D_FUNC,
      ST_RD_A,
      ST_RD_B,
      ST_ALU_RUN,
      ST_R_WAIT,
      ST_TX_RD,
      ST_TX_LSB,
      ST_TX_MSB
   } state_t;

   // ALU function codes carried in the low nibble of the func byte
   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_MUL = 4'd5
   } alu_func_t;

endpackage

// File: rtl/cmd_frame_ctrl_if.sv
// Bundle of the RX, register-file, ALU and TX signals around the
// command-frame controller. master = controller side, slave = peripherals.
interface cmd_frame_ctrl_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0]   rx_data;
   logic                rx_valid;

   logic [ADDR_W-1:0]   rf_addr;
   logic                rf_wr_en;
   logic [DATA_W-1:0]   rf_wr_data;
   logic                rf_rd_en;
   logic [DATA_W-1:0]   rf_rd_data;
   logic                rf_rd_valid;

   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic [3:0]          alu_func;
   logic                alu_en;
   logic [2*DATA_W-1:0] alu_out;
   logic                alu_valid;

   logic [DATA_W-1:0]   tx_data;
   logic                tx_valid;
   logic                tx_ready;

   logic                busy;

   modport master (
      input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_ready,
      output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_a, alu_b, alu_func, alu_en,
             tx_data, tx_valid, busy
   );

   modport slave (
      output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_valid, tx_ready,
      input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_a, alu_b, alu_func, alu_en,
             tx_data, tx_valid, busy
   );
endinterface

// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller: parses 0xAA/0xBB/0xCC/0xDD frames from the RX
// byte stream, sequences register-file reads/writes and one ALU operation,
// and offers response bytes to the TX path. Every output is a register.
module cmd_frame_ctrl
   import cmd_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic             ref_clk,
   input  logic             rst,
   cmd_frame_ctrl_if.master bus
);

   state_t              state_reg;
   logic [ADDR_W-1:0]   addr_a_reg;   // write address or ALU operand A address
   logic [ADDR_W-1:0]   addr_b_reg;   // ALU operand B address
   logic [DATA_W-1:0]   msb_reg;      // upper half of the ALU result, sent second

   // Frame FSM with all outputs registered; strobes default low each cycle
   always_ff @(posedge ref_clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         addr_a_reg      <= '0;
         addr_b_reg      <= '0;
         msb_reg         <= '0;
         bus.rf_addr     <= '0;
         bus.rf_wr_en    <= 1'b0;
         bus.rf_wr_data  <= '0;
         bus.rf_rd_en    <= 1'b0;
         bus.alu_a       <= '0;
         bus.alu_b       <= '0;
         bus.alu_func    <= '0;
         bus.alu_en      <= 1'b0;
         bus.tx_data     <= '0;
         bus.tx_valid    <= 1'b0;
         bus.busy        <= 1'b0;
      end else begin
         bus.rf_wr_en <= 1'b0;
         bus.rf_rd_en <= 1'b0;
         bus.alu_en   <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               if (bus.rx_valid) begin
                  case (bus.rx_data)
                     CMD_WR:      state_reg <= ST_W_ADDR;
                     CMD_RD:      state_reg <= ST_R_ADDR;
                     CMD_ALU:     state_reg <= ST_A_OPA;
                     CMD_ALU_NOP: state_reg <= ST_D_FUNC;
                     default:     state_reg <= ST_IDLE;   // unknown header dropped
                  endcase
               end
            end

            ST_W_ADDR: begin
               if (bus.rx_valid) begin
                  addr_a_reg <= bus.rx_data[ADDR_W-1:0];
                  state_reg  <= ST_W_DATA;
               end
            end

            ST_W_DATA: begin
               if (bus.rx_valid) begin
                  bus.rf_addr    <= addr_a_reg;
                  bus.rf_wr_data <= bus.rx_data;
                  bus.rf_wr_en   <= 1'b1;
                  state_reg      <= ST_IDLE;
               end
            end

            ST_R_ADDR: begin
               if (bus.rx_valid) begin
                  bus.rf_addr  <= bus.rx_data[ADDR_W-1:0];
                  bus.rf_rd_en <= 1'b1;
                  bus.busy     <= 1'b1;
                  state_reg    <= ST_R_WAIT;
               end
            end

            ST_A_OPA: begin
               if (bus.rx_valid) begin
                  addr_a_reg <= bus.rx_data[ADDR_W-1:0];
                  state_reg  <= ST_A_OPB;
               end
            end

            ST_A_OPB: begin
               if (bus.rx_valid) begin
                  addr_b_reg <= bus.rx_data[ADDR_W-1:0];
                  state_reg  <= ST_A_FUNC;
               end
            end

            // Func byte arrives: issue the operand-A read straight away
            ST_A_FUNC: begin
               if (bus.rx_valid) begin
                  bus.alu_func <= bus.rx_data[3:0];
                  bus.rf_addr  <= addr_a_reg;
                  bus.rf_rd_en <= 1'b1;
                  bus.busy     <= 1'b1;
                  state_reg    <= ST_RD_A;
               end
            end

            // Short form: operands are fixed to reg0 and reg1
            ST_D_FUNC: begin
               if (bus.rx_valid) begin
                  bus.alu_func <= bus.rx_data[3:0];
                  addr_b_reg   <= ADDR_W'(1);
                  bus.rf_addr  <= '0;
                  bus.rf_rd_en <= 1'b1;
                  bus.busy     <= 1'b1;
                  state_reg    <= ST_RD_A;
               end
            end

            ST_RD_A: begin
               if (bus.rf_rd_valid) begin
                  bus.alu_a    <= bus.rf_rd_data;
                  bus.rf_addr  <= addr_b_reg;
                  bus.rf_rd_en <= 1'b1;
                  state_reg    <= ST_RD_B;
               end
            end

            ST_RD_B: begin
               if (bus.rf_rd_valid) begin
                  bus.alu_b  <= bus.rf_rd_data;
                  bus.alu_en <= 1'b1;
                  state_reg  <= ST_ALU_RUN;
               end
            end

            ST_ALU_RUN: begin
               if (bus.alu_valid) begin
                  bus.tx_data  <= bus.alu_out[DATA_W-1:0];
                  msb_reg      <= bus.alu_out[2*DATA_W-1:DATA_W];
                  bus.tx_valid <= 1'b1;
                  state_reg    <= ST_TX_LSB;
               end
            end

            ST_R_WAIT: begin
               if (bus.rf_rd_valid) begin
                  bus.tx_data  <= bus.rf_rd_data;
                  bus.tx_valid <= 1'b1;
                  state_reg    <= ST_TX_RD;
               end
            end

            // LSB accepted: keep tx_valid high and swap in the MSB
            ST_TX_LSB: begin
               if (bus.tx_ready) begin
                  bus.tx_data <= msb_reg;
                  state_reg   <= ST_TX_MSB;
               end
            end

            ST_TX_RD, ST_TX_MSB: begin
               if (bus.tx_ready) begin
                  bus.tx_valid <= 1'b0;
                  bus.busy     <= 1'b0;
                  state_reg    <= ST_IDLE;
               end
            end

            default: begin
               bus.tx_valid <= 1'b0;
               bus.busy     <= 1'b0;
               state_reg    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Table-driven bench for cmd_frame_ctrl with behavioural register-file,
// ALU and TX-sink models, plus hand sequences for latency, TX stall and reset.
module tb_cmd_frame_ctrl;

   localparam int RD_LAT  = 2;
   localparam int ALU_LAT = 3;

   logic   ref_clk = 1'b0;
   logic   rst;
   longint cyc = 0;

   cmd_frame_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

   cmd_frame_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
      .ref_clk (ref_clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 ref_clk = ~ref_clk;

   always @(posedge ref_clk) cyc++;

   // ---------------- environment models (observe, then drive) ----------------
   logic [7:0] rf_mem [16];
   bit         tx_stall = 1'b0;
   bit         rd_pend = 1'b0;
   int         rd_left;
   logic [3:0] rd_addr;
   bit         alu_pend = 1'b0;
   int         alu_left;
   logic [7:0] cap_a, cap_b;
   logic [3:0] cap_func;
   int         wr_cnt = 0, rd_cnt = 0;
   logic [3:0] last_wr_addr;
   logic [7:0] last_wr_data;
   longint     wr_cyc = -1, last_rx_cyc = -1;
   bit         tx_valid_prev = 1'b0;
   longint     tx_q[$], tx_acc_q[$], tx_rise_q[$];
   longint     rd_en_q[$], rdv_q[$], alu_en_q[$], alu_v_q[$];

   function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
      case (f)
         4'd0:    return 16'(a) + 16'(b);
         4'd1:    return 16'(a) - 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   // Sample DUT outputs mid-cycle and drive peripheral responses
   always @(negedge ref_clk) begin
      if (bus.rx_valid) last_rx_cyc = cyc;
      if (bus.rf_wr_en) begin
         wr_cnt++;
         last_wr_addr = bus.rf_addr;
         last_wr_data = bus.rf_wr_data;
         rf_mem[bus.rf_addr] = bus.rf_wr_data;
         wr_cyc = cyc;
      end
      if (bus.rf_rd_valid) rdv_q.push_back(cyc);
      if (bus.alu_valid) alu_v_q.push_back(cyc);
      if (bus.rf_rd_en) begin
         rd_cnt++;
         rd_en_q.push_back(cyc);
         rd_pend = 1'b1;
         rd_left = RD_LAT;
         rd_addr = bus.rf_addr;
      end
      if (bus.alu_en) begin
         alu_en_q.push_back(cyc);
         alu_pend = 1'b1;
         alu_left = ALU_LAT;
         cap_a    = bus.alu_a;
         cap_b    = bus.alu_b;
         cap_func = bus.alu_func;
      end
      if (bus.tx_valid && !tx_valid_prev) tx_rise_q.push_back(cyc);
      tx_valid_prev = bus.tx_valid;

      bus.tx_ready = !tx_stall;
      if (bus.tx_valid && bus.tx_ready) begin
         tx_q.push_back(longint'(bus.tx_data));
         tx_acc_q.push_back(cyc);
      end

      bus.rf_rd_valid = 1'b0;
      bus.rf_rd_data  = 8'($urandom);
      if (rd_pend) begin
         rd_left--;
         if (rd_left == 0) begin
            bus.rf_rd_valid = 1'b1;
            bus.rf_rd_data  = rf_mem[rd_addr];
            rd_pend = 1'b0;
         end
      end

      bus.alu_valid = 1'b0;
      bus.alu_out   = 16'($urandom);
      if (alu_pend) begin
         alu_left--;
         if (alu_left == 0) begin
            bus.alu_valid = 1'b1;
            bus.alu_out   = alu_ref(cap_func, cap_a, cap_b);
            alu_pend = 1'b0;
         end
      end
   end

   // ---------------- checking helpers ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic longint qget(input longint q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge ref_clk); #1;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge ref_clk); #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic wait_done(input int tx_base, input int ntx, input string nm);
      bit done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge ref_clk); #2;
         if (tx_q.size() - tx_base >= ntx && !bus.busy && !bus.tx_valid) done = 1'b1;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL %s/timeout: got busy=%0b tx_bytes=%0d, expected idle with %0d bytes",
                  nm, bus.busy, tx_q.size() - tx_base, ntx);
      end
      repeat (4) @(negedge ref_clk);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      logic [31:0] frame;    // first byte in [31:24]
      int          nbytes;
      int          ntx;
      logic [7:0]  tx0, tx1;
      bit          wr;
      logic [3:0]  wr_addr;
      logic [7:0]  wr_data;
      bit          alu;
      logic [3:0]  func;
      logic [7:0]  a, b;
   } vec_t;

   function automatic vec_t mk(input string nm, input logic [31:0] fr, input int nb, input int ntx,
                               input logic [7:0] t0, input logic [7:0] t1,
                               input bit wr, input logic [3:0] wa, input logic [7:0] wd,
                               input bit alu, input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
      vec_t v;
      v.name = nm; v.frame = fr; v.nbytes = nb; v.ntx = ntx; v.tx0 = t0; v.tx1 = t1;
      v.wr = wr; v.wr_addr = wa; v.wr_data = wd;
      v.alu = alu; v.func = f; v.a = a; v.b = b;
      return v;
   endfunction

   localparam int NV = 17;
   vec_t vecs [NV];

   initial begin
      int   txb, wrb, rdb, rvb, trb, aeb, avb, tab;
      bit   stable_ok;
      bit   seen;

      vecs[0]  = mk("wr5",       32'hAA052600, 3, 0, 8'h00, 8'h00, 1, 4'h5, 8'h26, 0, 4'h0, 8'h00, 8'h00);
      vecs[1]  = mk("rd5",       32'hBB050000, 2, 1, 8'h26, 8'h00, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 8'h00);
      vecs[2]  = mk("wr7",       32'hAA073100, 3, 0, 8'h00, 8'h00, 1, 4'h7, 8'h31, 0, 4'h0, 8'h00, 8'h00);
      vecs[3]  = mk("wr8",       32'hAA083000, 3, 0, 8'h00, 8'h00, 1, 4'h8, 8'h30, 0, 4'h0, 8'h00, 8'h00);
      vecs[4]  = mk("alu_5_7",   32'hCC050700, 4, 2, 8'h57, 8'h00, 0, 4'h0, 8'h00, 1, 4'h0, 8'h26, 8'h31);
      vecs[5]  = mk("alu_7_8",   32'hCC070800, 4, 2, 8'h61, 8'h00, 0, 4'h0, 8'h00, 1, 4'h0, 8'h31, 8'h30);
      vecs[6]  = mk("wr0",       32'hAA000300, 3, 0, 8'h00, 8'h00, 1, 4'h0, 8'h03, 0, 4'h0, 8'h00, 8'h00);
      vecs[7]  = mk("wr1",       32'hAA010100, 3, 0, 8'h00, 8'h00, 1, 4'h1, 8'h01, 0, 4'h0, 8'h00, 8'h00);
      vecs[8]  = mk("nop_sub",   32'hDD010000, 2, 2, 8'h02, 8'h00, 0, 4'h0, 8'h00, 1, 4'h1, 8'h03, 8'h01);
      vecs[9]  = mk("unknown",   32'h5A000000, 1, 0, 8'h00, 8'h00, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 8'h00);
      vecs[10] = mk("rd5_again", 32'hBB050000, 2, 1, 8'h26, 8'h00, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 8'h00);
      vecs[11] = mk("wr_trunc",  32'hAAF37700, 3, 0, 8'h00, 8'h00, 1, 4'h3, 8'h77, 0, 4'h0, 8'h00, 8'h00);
      vecs[12] = mk("rd_trunc",  32'hBB130000, 2, 1, 8'h77, 8'h00, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 8'h00);
      vecs[13] = mk("wrC",       32'hAA0CC800, 3, 0, 8'h00, 8'h00, 1, 4'hC, 8'hC8, 0, 4'h0, 8'h00, 8'h00);
      vecs[14] = mk("wrD",       32'hAA0D6400, 3, 0, 8'h00, 8'h00, 1, 4'hD, 8'h64, 0, 4'h0, 8'h00, 8'h00);
      vecs[15] = mk("add_carry", 32'hCC0C0D00, 4, 2, 8'h2C, 8'h01, 0, 4'h0, 8'h00, 1, 4'h0, 8'hC8, 8'h64);
      vecs[16] = mk("sub_neg",   32'hCC0100F1, 4, 2, 8'hFE, 8'hFF, 0, 4'h0, 8'h00, 1, 4'h1, 8'h01, 8'h03);

      rst          = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge ref_clk);
      #1;
      check("reset_outputs",
            {bus.rf_addr, bus.rf_wr_en, bus.rf_wr_data, bus.rf_rd_en, bus.alu_a, bus.alu_b,
             bus.alu_func, bus.alu_en, bus.tx_data, bus.tx_valid, bus.busy}, 64'h0);
      rst = 1'b0;
      repeat (2) @(negedge ref_clk);

      // -------- table-driven frames --------
      for (int v = 0; v < NV; v++) begin
         txb = tx_q.size();
         wrb = wr_cnt;
         for (int i = 0; i < vecs[v].nbytes; i++) send_byte(vecs[v].frame[31-8*i -: 8]);
         wait_done(txb, vecs[v].ntx, vecs[v].name);
         check({vecs[v].name, "/tx_count"}, 64'(tx_q.size() - txb), 64'(vecs[v].ntx));
         if (vecs[v].ntx > 0) check({vecs[v].name, "/tx0"}, qget(tx_q, txb), 64'(vecs[v].tx0));
         if (vecs[v].ntx > 1) check({vecs[v].name, "/tx1"}, qget(tx_q, txb + 1), 64'(vecs[v].tx1));
         check({vecs[v].name, "/wr_count"}, 64'(wr_cnt - wrb), vecs[v].wr ? 64'd1 : 64'd0);
         if (vecs[v].wr) begin
            check({vecs[v].name, "/wr_addr"}, 64'(last_wr_addr), 64'(vecs[v].wr_addr));
            check({vecs[v].name, "/wr_data"}, 64'(last_wr_data), 64'(vecs[v].wr_data));
         end
         if (vecs[v].alu) begin
            check({vecs[v].name, "/alu_func"}, 64'(cap_func), 64'(vecs[v].func));
            check({vecs[v].name, "/alu_a"}, 64'(cap_a), 64'(vecs[v].a));
            check({vecs[v].name, "/alu_b"}, 64'(cap_b), 64'(vecs[v].b));
         end
         $display("vector %0d %s done", v, vecs[v].name);
      end

      // -------- strobe latencies --------
      send_byte(8'hAA); send_byte(8'h0B); send_byte(8'h5E);
      wait_done(tx_q.size(), 0, "lat_wr");
      check("lat_wr_en", 64'(wr_cyc), 64'(last_rx_cyc));

      txb = tx_q.size(); rdb = rd_en_q.size(); rvb = rdv_q.size(); trb = tx_rise_q.size();
      send_byte(8'hBB); send_byte(8'h0B);
      wait_done(txb, 1, "lat_rd");
      check("lat_rd_en", qget(rd_en_q, rdb), 64'(last_rx_cyc));
      check("lat_rd_tx_valid", qget(tx_rise_q, trb), qget(rdv_q, rvb));
      check("lat_rd_byte", qget(tx_q, txb), 64'h5E);

      txb = tx_q.size(); rdb = rd_en_q.size(); rvb = rdv_q.size(); trb = tx_rise_q.size();
      aeb = alu_en_q.size(); avb = alu_v_q.size(); tab = tx_acc_q.size();
      send_byte(8'hCC); send_byte(8'h0B); send_byte(8'h0B); send_byte(8'h00);
      wait_done(txb, 2, "lat_alu");
      check("lat_rd_a", qget(rd_en_q, rdb), 64'(last_rx_cyc));
      check("lat_rd_b", qget(rd_en_q, rdb + 1), qget(rdv_q, rvb));
      check("lat_alu_en", qget(alu_en_q, aeb), qget(rdv_q, rvb + 1));
      check("lat_alu_tx_valid", qget(tx_rise_q, trb), qget(alu_v_q, avb));
      check("lat_msb_follow", qget(tx_acc_q, tab + 1), qget(tx_acc_q, tab) + 1);
      check("lat_alu_lsb", qget(tx_q, txb), 64'hBC);
      check("lat_alu_msb", qget(tx_q, txb + 1), 64'h00);
      $display("latency sequence done");

      // -------- TX stall with RX bytes arriving meanwhile --------
      tx_stall = 1'b1;
      txb = tx_q.size(); wrb = wr_cnt;
      send_byte(8'hCC); send_byte(8'h05); send_byte(8'h07); send_byte(8'h00);
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge ref_clk); #2;
         if (bus.tx_valid) seen = 1'b1;
      end
      check("stall_tx_offered", 64'(seen), 64'd1);
      rdb = rd_cnt;
      stable_ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge ref_clk); #1;
         bus.rx_valid = (i == 10 || i == 20 || i == 30);
         bus.rx_data  = (i == 10) ? 8'hAA : (i == 20) ? 8'h09 : 8'h99;
         #1;
         if (!(bus.tx_valid === 1'b1 && bus.tx_data === 8'h57)) stable_ok = 1'b0;
      end
      @(negedge ref_clk); #1;
      bus.rx_valid = 1'b0;
      check("stall_stable", 64'(stable_ok), 64'd1);
      check("stall_no_accept", 64'(tx_q.size() - txb), 64'd0);
      check("stall_busy", 64'(bus.busy), 64'd1);
      check("stall_rx_no_rd", 64'(rd_cnt - rdb), 64'd0);
      tx_stall = 1'b0;
      wait_done(txb, 2, "stall");
      check("stall_lsb", qget(tx_q, txb), 64'h57);
      check("stall_msb", qget(tx_q, txb + 1), 64'h00);
      check("stall_rx_no_wr", 64'(wr_cnt - wrb), 64'd0);
      $display("tx stall sequence done");

      // -------- reset in A_OPB, then a clean write frame --------
      send_byte(8'hCC); send_byte(8'h05);
      @(negedge ref_clk); #1;
      rst = 1'b1;
      @(negedge ref_clk); #1;
      rst = 1'b0;
      check("rst_mid_outputs",
            {bus.rf_addr, bus.rf_wr_en, bus.rf_wr_data, bus.rf_rd_en, bus.alu_a, bus.alu_b,
             bus.alu_func, bus.alu_en, bus.tx_data, bus.tx_valid, bus.busy}, 64'h0);
      txb = tx_q.size(); wrb = wr_cnt; rdb = rd_cnt;
      send_byte(8'h07); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'h0A); send_byte(8'h5C);
      wait_done(txb, 0, "rst_mid");
      check("rst_mid_no_rd", 64'(rd_cnt - rdb), 64'd0);
      check("rst_mid_no_tx", 64'(tx_q.size() - txb), 64'd0);
      check("rst_mid_wr_count", 64'(wr_cnt - wrb), 64'd1);
      check("rst_mid_wr_addr", 64'(last_wr_addr), 64'hA);
      check("rst_mid_wr_data", 64'(last_wr_data), 64'h5C);
      txb = tx_q.size();
      send_byte(8'hBB); send_byte(8'h0A);
      wait_done(txb, 1, "rst_mid_rd");
      check("rst_mid_rd_byte", qget(tx_q, txb), 64'h5C);
      $display("mid-frame reset sequence done");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by %0t, expected bench to finish", $time);
      $fatal(1);
   end

endmodule
